// File: rtl/rgb_pwm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rgb_pwm_pkg : shared types and constants for the RGB PWM block    |
// | Revision    : 1.0                                                 |
// +------------------------------------------------------------------+
package rgb_pwm_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } breathe_state_t;

  localparam logic [1:0] CH_R   = 2'd0;
  localparam logic [1:0] CH_G   = 2'd1;
  localparam logic [1:0] CH_B   = 2'd2;
  localparam logic [1:0] CH_ALL = 2'd3;

  // Upper byte of duty*level: the breathe-scaled duty.
  function automatic logic [DUTY_W-1:0] scale_duty(input logic [DUTY_W-1:0] duty,
                                                   input logic [7:0] level);
    logic [2*DUTY_W-1:0] prod;
    prod = {{DUTY_W{1'b0}}, duty} * {{DUTY_W{1'b0}}, level};
    return prod[2*DUTY_W-1:DUTY_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_pwm_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rgb_pwm_if : valid/ready duty write port                          |
// | Revision   : 1.0                                                  |
// +------------------------------------------------------------------+
interface rgb_pwm_if;
  import rgb_pwm_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [1:0]        wr_chan;
  logic [DUTY_W-1:0] wr_duty;

  modport master (output wr_valid, output wr_chan, output wr_duty, input wr_ready);
  modport slave  (input wr_valid, input wr_chan, input wr_duty, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_prescaler : one-clk step strobe every PRESCALE clocks         |
// | Revision      : 1.0                                               |
// +------------------------------------------------------------------+
module pwm_prescaler #(
  parameter int PRESCALE = 48
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_step
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_q;

  // With PRESCALE=1 the count is pinned at 0, so the strobe is always high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (count_q == C_LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign o_step = (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/rgb_pwm_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rgb_pwm_gen : 3-channel double-buffered PWM with breathe mode     |
// | Revision    : 1.0                                                 |
// +------------------------------------------------------------------+
module rgb_pwm_gen
  import rgb_pwm_pkg::*;
#(
  parameter int PRESCALE    = 48,
  parameter int BREATHE_DIV = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  rgb_pwm_if.slave   wr,
  input  logic       i_breathe_en,
  output logic [2:0] o_pwm,
  output logic       o_period_tick
);

  localparam int DW = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;
  localparam logic [DW-1:0] C_DIV_LAST = DW'(BREATHE_DIV - 1);

  logic                         w_step, w_boundary, w_accept, w_div_exp;
  logic [7:0]                   cnt_q;
  logic [2:0][DUTY_W-1:0]       shadow_q, shadow_d, active_q, eff_q, eff_d;
  logic                         pending_q, pending_d;
  logic [DW-1:0]                div_q;
  breathe_state_t               state_q, state_d;
  logic [7:0]                   level_q, level_d;
  logic [2:0]                   pwm_q;
  logic                         tick_q;

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_step (w_step)
  );

  assign w_boundary  = w_step && (cnt_q == 8'hFF);
  assign wr.wr_ready = !pending_q;
  assign w_accept    = wr.wr_valid && !pending_q;
  assign w_div_exp   = (div_q == C_DIV_LAST);

  always_comb begin
    shadow_d = shadow_q;
    if (w_accept) begin
      for (int c = 0; c < 3; c++) begin
        if (wr.wr_chan == CH_ALL || wr.wr_chan == 2'(c)) shadow_d[c] = wr.wr_duty;
      end
    end
  end

  // An accept in the boundary clock wins, so that value waits one more period.
  assign pending_d = w_accept ? 1'b1 : (w_boundary ? 1'b0 : pending_q);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (w_boundary) begin
      if (!i_breathe_en) begin
        state_d = ST_OFF;
        level_d = 8'd0;
      end else if (w_div_exp) begin
        case (state_q)
          ST_OFF: begin
            state_d = ST_UP;
            level_d = 8'd0;
          end
          ST_UP: begin
            if (level_q == 8'hFF) state_d = ST_DOWN;
            else                  level_d = level_q + 8'd1;
          end
          ST_DOWN: begin
            if (level_q == 8'd0) state_d = ST_UP;
            else                 level_d = level_q - 8'd1;
          end
          default: begin
            state_d = ST_OFF;
            level_d = 8'd0;
          end
        endcase
      end
    end
  end

  // Effective duty sees the active value and level that take effect at this boundary.
  always_comb begin
    eff_d = '0;
    for (int c = 0; c < 3; c++) begin
      eff_d[c] = (state_d == ST_OFF) ? shadow_q[c] : scale_duty(shadow_q[c], level_d);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q     <= 8'd0;
      shadow_q  <= '0;
      active_q  <= '0;
      eff_q     <= '0;
      pending_q <= 1'b0;
      div_q     <= '0;
      state_q   <= ST_OFF;
      level_q   <= 8'd0;
      pwm_q     <= 3'b000;
      tick_q    <= 1'b0;
    end else begin
      if (w_step) cnt_q <= cnt_q + 8'd1;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      level_q   <= level_d;
      tick_q    <= w_boundary;
      if (w_boundary) begin
        active_q <= shadow_q;
        eff_q    <= eff_d;
        if (!i_breathe_en || w_div_exp) div_q <= '0;
        else                            div_q <= div_q + 1'b1;
      end
      for (int c = 0; c < 3; c++) begin
        pwm_q[c] <= (cnt_q < eff_q[c]);
      end
    end
  end

  assign o_pwm         = pwm_q;
  assign o_period_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rgb_pwm_gen : randomized scoreboard bench for rgb_pwm_gen      |
// | Revision       : 1.0                                              |
// +------------------------------------------------------------------+
module tb_rgb_pwm_gen;
  import rgb_pwm_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ben = 1'b0;
  logic [2:0] pwm, pwm48;
  logic       tick, tick48;

  int checks = 0;
  int errors = 0;

  bit mon_en  = 1'b0;
  bit start48 = 1'b0;
  bit done48  = 1'b0;

  logic [23:0] exp_q[$];

  int m_shadow[3];
  int m_active[3];
  bit m_pend;
  int m_state;   // 0 = off, 1 = rising, 2 = falling
  int m_level;

  always #5 clk = ~clk;

  rgb_pwm_if wr_if ();
  rgb_pwm_if wr48_if ();

  rgb_pwm_gen #(.PRESCALE(1), .BREATHE_DIV(1)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .wr            (wr_if),
    .i_breathe_en  (ben),
    .o_pwm         (pwm),
    .o_period_tick (tick)
  );

  rgb_pwm_gen #(.PRESCALE(48), .BREATHE_DIV(16)) dut48 (
    .i_clk         (clk),
    .i_rst         (rst),
    .wr            (wr48_if),
    .i_breathe_en  (1'b0),
    .o_pwm         (pwm48),
    .o_period_tick (tick48)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_eff(input int active);
    return (m_state == 0) ? active : (active * m_level) / 256;
  endfunction

  task automatic model_write(input int chan, input int duty);
    for (int c = 0; c < 3; c++) begin
      if (chan == 3 || chan == c) m_shadow[c] = duty;
    end
  endtask

  // One PWM period of 256 clocks; an optional write at clock j (256 = boundary clock).
  task automatic do_period(input bit wr, input int chan, input int duty, input int j, input bit en);
    bit drive, acc;
    ben = en;
    for (int k = 1; k <= 256; k++) begin
      chk("wr_ready", int'(wr_if.wr_ready), int'(!m_pend));
      drive = wr && (k == j);
      wr_if.wr_valid = drive;
      wr_if.wr_chan  = 2'(chan);
      wr_if.wr_duty  = 8'(duty);
      @(posedge clk);
      acc = drive && !m_pend;
      if (k < 256) begin
        if (acc) begin
          model_write(chan, duty);
          m_pend = 1'b1;
        end
      end else begin
        for (int c = 0; c < 3; c++) m_active[c] = m_shadow[c];
        m_pend = 1'b0;
        if (acc) begin
          model_write(chan, duty);
          m_pend = 1'b1;
        end
        if (!en) begin
          m_state = 0;
          m_level = 0;
        end else if (m_state == 0) begin
          m_state = 1;
          m_level = 0;
        end else if (m_state == 1) begin
          if (m_level == 255) m_state = 2;
          else                m_level = m_level + 1;
        end else begin
          if (m_level == 0) m_state = 1;
          else              m_level = m_level - 1;
        end
        exp_q.push_back({8'(model_eff(m_active[2])), 8'(model_eff(m_active[1])),
                         8'(model_eff(m_active[0]))});
      end
      @(negedge clk);
    end
    wr_if.wr_valid = 1'b0;
  endtask

  // Monitor: counts high clocks per channel between ticks and checks against the scoreboard.
  initial begin
    int cyc;
    int hi[3];
    bit started;
    logic [23:0] e;
    cyc = 0;
    started = 1'b0;
    for (int c = 0; c < 3; c++) hi[c] = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cyc++;
        for (int c = 0; c < 3; c++) hi[c] += int'(pwm[c]);
        if (tick) begin
          chk("period_len", cyc, 256);
          if (started) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL scoreboard_empty: got tick, expected no period end");
            end else begin
              e = exp_q.pop_front();
              chk("high_r", hi[0], int'(e[7:0]));
              chk("high_g", hi[1], int'(e[15:8]));
              chk("high_b", hi[2], int'(e[23:16]));
            end
          end
          started = 1'b1;
          cyc = 0;
          for (int c = 0; c < 3; c++) hi[c] = 0;
        end else if (cyc > 300) begin
          checks++;
          errors++;
          $display("FAIL tick_timeout: got %0d clk without tick, expected 256", cyc);
          cyc = 0;
        end
      end
    end
  end

  // Slow-prescaler instance: period length and high time with duty 128.
  initial begin
    int n, h;
    wr48_if.wr_valid = 1'b0;
    wr48_if.wr_chan  = CH_R;
    wr48_if.wr_duty  = 8'd0;
    wait (start48);
    @(negedge clk);
    wr48_if.wr_valid = 1'b1;
    wr48_if.wr_duty  = 8'd128;
    @(negedge clk);
    wr48_if.wr_valid = 1'b0;
    n = 0;
    while (!tick48 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("p48_first_tick_seen", int'(tick48), 1);
    n = 0;
    h = 0;
    do begin
      @(negedge clk);
      n++;
      h += int'(pwm48[0]);
    end while (!tick48 && n < 20000);
    chk("p48_period", n, 12288);
    chk("p48_high", h, 6144);
    done48 = 1'b1;
  end

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_chan  = CH_R;
    wr_if.wr_duty  = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_chan  = CH_ALL;
    wr_if.wr_duty  = 8'd255;
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    repeat (400) @(negedge clk);
    chk("pre_reset_pwm", int'(pwm), 7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pwm", int'(pwm), 0);
    chk("async_rst_ready", int'(wr_if.wr_ready), 1);
    chk("async_rst_tick", int'(tick), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      m_shadow[c] = 0;
      m_active[c] = 0;
    end
    m_pend  = 1'b0;
    m_state = 0;
    m_level = 0;
    mon_en  = 1'b1;
    start48 = 1'b1;

    do_period(1'b1, CH_R, 64, 10, 1'b0);
    do_period(1'b0, 0, 0, 1, 1'b0);
    do_period(1'b1, CH_ALL, 255, 100, 1'b0);
    do_period(1'b0, 0, 0, 1, 1'b0);
    do_period(1'b1, CH_ALL, 0, 30, 1'b0);
    do_period(1'b0, 0, 0, 1, 1'b0);
    do_period(1'b1, CH_G, 200, 256, 1'b0);
    do_period(1'b1, CH_B, 77, 40, 1'b0);
    do_period(1'b0, 0, 0, 1, 1'b0);
    for (int p = 0; p < 14; p++) begin
      do_period($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 255)), int'($urandom_range(1, 256)), 1'b0);
    end
    do_period(1'b1, CH_R, 255, 5, 1'b0);
    for (int p = 0; p < 262; p++) begin
      do_period((p % 40) == 20, int'($urandom_range(1, 2)), int'($urandom_range(0, 255)),
                int'($urandom_range(1, 255)), 1'b1);
    end
    do_period(1'b0, 0, 0, 1, 1'b0);
    do_period(1'b0, 0, 0, 1, 1'b0);
    repeat (3) @(negedge clk);
    chk("prescale48_done", int'(done48), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
